// File: rtl/pipe_pkg.sv
// pipe_pkg: shared constants and control-bundle packing for the core's stage registers
package pipe_pkg;
  localparam int CTRL_W = 8;
  localparam logic [31:0] NOP_INSN = 32'h00000013;
  localparam int REG_WE_BIT = 0;
  localparam int DMEM_SEL_LSB = 1;
  localparam int LOAD_SEL_LSB = 3;
  localparam int WB_SEL_LSB = 6;
  function automatic logic [CTRL_W-1:0] pack_ctrl(input logic reg_we, input logic [1:0] dmem_sel,
                                                  input logic [2:0] load_sel, input logic [1:0] wb_sel);
    logic [CTRL_W-1:0] c;
    c = '0;
    c[REG_WE_BIT] = reg_we;
    c[DMEM_SEL_LSB +: 2] = dmem_sel;
    c[LOAD_SEL_LSB +: 3] = load_sel;
    c[WB_SEL_LSB +: 2] = wb_sel;
    return c;
  endfunction
endpackage

// File: rtl/pipe_entry_reg.sv
// pipe_entry_reg: valid+insn+data+ctrl register with load enable and sync clear of valid
module pipe_entry_reg
  import pipe_pkg::*;
#(
  parameter int DW = 96,
  parameter int CW = 8,
  parameter logic [31:0] RST_INSN = NOP_INSN
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld,
  input  logic          clr,
  input  logic [31:0]   d_insn,
  input  logic [DW-1:0] d_data,
  input  logic [CW-1:0] d_ctrl,
  output logic          q_valid,
  output logic [31:0]   q_insn,
  output logic [DW-1:0] q_data,
  output logic [CW-1:0] q_ctrl
);
  always_ff @(posedge clk) begin
    if (rst) begin
      q_valid <= 1'b0;
      q_insn <= RST_INSN;
      q_data <= '0;
      q_ctrl <= '0;
    end else if (ld) begin
      q_valid <= 1'b1;
      q_insn <= d_insn;
      q_data <= d_data;
      q_ctrl <= d_ctrl;
    end else if (clr) begin
      q_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: elastic stage register with two-entry skid buffer, flush and occupancy
module pipe_skid_reg #(
  parameter int DATA_W = 96,
  parameter int CTRL_W = pipe_pkg::CTRL_W,
  parameter logic [31:0] NOP_INSN = pipe_pkg::NOP_INSN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_insn,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_insn,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);
  logic m_valid, s_valid, acc, fire, m_ld, m_clr, s_ld, s_clr;
  logic [31:0] m_insn, s_insn, m_d_insn;
  logic [DATA_W-1:0] s_data, m_d_data;
  logic [CTRL_W-1:0] m_ctrl, s_ctrl, m_d_ctrl;
  assign in_ready = !s_valid;
  assign acc = in_valid & in_ready;
  assign fire = m_valid & out_ready;
  // skid entry drains into main first; otherwise main takes the input whenever it frees up
  assign m_ld = !flush & ((s_valid & fire) | (acc & (!m_valid | fire)));
  assign m_clr = flush | fire;
  assign s_ld = !flush & m_valid & !fire & acc;
  assign s_clr = flush | (s_valid & fire);
  assign m_d_insn = s_valid ? s_insn : in_insn;
  assign m_d_data = s_valid ? s_data : in_data;
  assign m_d_ctrl = s_valid ? s_ctrl : in_ctrl;
  pipe_entry_reg #(.DW(DATA_W), .CW(CTRL_W), .RST_INSN(NOP_INSN)) u_main (
    .clk(clk), .rst(rst), .ld(m_ld), .clr(m_clr),
    .d_insn(m_d_insn), .d_data(m_d_data), .d_ctrl(m_d_ctrl),
    .q_valid(m_valid), .q_insn(m_insn), .q_data(out_data), .q_ctrl(m_ctrl)
  );
  pipe_entry_reg #(.DW(DATA_W), .CW(CTRL_W), .RST_INSN(NOP_INSN)) u_skid (
    .clk(clk), .rst(rst), .ld(s_ld), .clr(s_clr),
    .d_insn(in_insn), .d_data(in_data), .d_ctrl(in_ctrl),
    .q_valid(s_valid), .q_insn(s_insn), .q_data(s_data), .q_ctrl(s_ctrl)
  );
  assign out_valid = m_valid;
  assign out_insn = m_valid ? m_insn : NOP_INSN;
  assign out_ctrl = m_valid ? m_ctrl : '0;
  assign occupancy = {1'b0, m_valid} + {1'b0, s_valid};
endmodule
